// File: rtl/fft_stage_sequencer.sv
// Runtime-configurable address/control sequencer for an in-place radix-2 DIT FFT.
// A single FSM walks every stage, drains the butterfly pipeline, then paces read-out.
module fft_stage_sequencer #(
    parameter int MAX_LOG = 10,
    parameter int WB_LAT  = 3,
    parameter int TW_W    = MAX_LOG - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         log2n,
    input  logic               inverse,
    input  logic               bitrev_out,
    input  logic               en_out,
    output logic               busy,
    output logic               rd_en,
    output logic [MAX_LOG-1:0] rd_ptr,
    output logic [TW_W-1:0]    rd_angle,
    output logic               tw_conj,
    output logic [3:0]         stage,
    output logic               wr_en,
    output logic [MAX_LOG-1:0] wr_ptr,
    output logic               finish_fft,
    output logic               out_valid,
    output logic               done
);
    localparam int BW = MAX_LOG - 1;
    localparam int DW = $clog2(WB_LAT + 1);

    typedef enum logic [2:0] {IDLE, COMPUTE, DRAIN, OUTPUT, DONE} state_t;

    state_t             state, state_n;
    logic [3:0]         len_log, len_log_n;
    logic               brev, brev_n;
    logic [3:0]         stage_n;
    logic [BW-1:0]      b, b_n, b_last;
    logic               leg, leg_n;
    logic [DW-1:0]      dcnt, dcnt_n;
    logic [MAX_LOG:0]   oi, oi_n, n_len;
    logic               busy_n, rd_en_n, conj_n, fin_n, ov_n, done_n;
    logic [MAX_LOG-1:0] ptr_n;
    logic [TW_W-1:0]    ang_n;
    logic               en_sr  [WB_LAT];
    logic [MAX_LOG-1:0] ptr_sr [WB_LAT];

    function automatic logic [3:0] clamp_log(input logic [3:0] v);
        if (v == 4'd0) return 4'd1;
        if (v > 4'(MAX_LOG)) return 4'(MAX_LOG);
        return v;
    endfunction

    function automatic logic [MAX_LOG-1:0] low_mask(input logic [3:0] sv);
        return (MAX_LOG'(1) << sv) - MAX_LOG'(1);
    endfunction

    // g*2h + p + leg*h is b with the leg bit inserted at position s
    function automatic logic [MAX_LOG-1:0] bfly_addr(input logic [3:0] sv, input logic [BW-1:0] bv,
                                                     input logic lv);
        logic [MAX_LOG-1:0] bx;
        bx = MAX_LOG'(bv);
        return ((bx & ~low_mask(sv)) << 1) | (bx & low_mask(sv)) | (MAX_LOG'(lv) << sv);
    endfunction

    function automatic logic [TW_W-1:0] bfly_angle(input logic [3:0] sv, input logic [BW-1:0] bv);
        return TW_W'(MAX_LOG'(bv) & low_mask(sv)) << (4'(MAX_LOG - 1) - sv);
    endfunction

    function automatic logic [MAX_LOG-1:0] bit_rev(input logic [MAX_LOG-1:0] v, input logic [3:0] lv);
        logic [MAX_LOG-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < MAX_LOG; k++) r[k] = v[MAX_LOG-1-k];
        return r >> (4'(MAX_LOG) - lv);
    endfunction

    assign n_len  = (MAX_LOG+1)'(1) << len_log;
    assign b_last = BW'((n_len >> 1) - (MAX_LOG+1)'(1));

    always_comb begin
        state_n   = state;
        len_log_n = len_log;
        brev_n    = brev;
        conj_n    = tw_conj;
        stage_n   = stage;
        b_n       = b;
        leg_n     = leg;
        dcnt_n    = dcnt;
        oi_n      = oi;
        rd_en_n   = 1'b0;
        ptr_n     = '0;
        ang_n     = '0;
        fin_n     = 1'b0;
        ov_n      = 1'b0;
        done_n    = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n   = COMPUTE;
                len_log_n = clamp_log(log2n);
                brev_n    = bitrev_out;
                conj_n    = inverse;
                stage_n   = '0;
                b_n       = '0;
                leg_n     = 1'b0;
                dcnt_n    = '0;
                oi_n      = '0;
                rd_en_n   = 1'b1;
            end
            COMPUTE: begin
                if (leg && b == b_last) begin
                    state_n = DRAIN;
                    dcnt_n  = '0;
                end else begin
                    leg_n   = ~leg;
                    b_n     = leg ? b + BW'(1) : b;
                    rd_en_n = 1'b1;
                    ptr_n   = bfly_addr(stage, b_n, leg_n);
                    ang_n   = bfly_angle(stage, b_n);
                end
            end
            DRAIN: begin
                if (dcnt == DW'(WB_LAT - 1)) begin
                    if (stage < len_log - 4'd1) begin
                        state_n = COMPUTE;
                        stage_n = stage + 4'd1;
                        b_n     = '0;
                        leg_n   = 1'b0;
                        rd_en_n = 1'b1;
                    end else begin
                        state_n = OUTPUT;
                        fin_n   = 1'b1;
                        oi_n    = '0;
                    end
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            OUTPUT: begin
                // oi == N means the last address has gone out; done follows a cycle later
                if (oi == n_len) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (en_out) begin
                    ov_n  = 1'b1;
                    ptr_n = brev ? bit_rev(oi[MAX_LOG-1:0], len_log) : oi[MAX_LOG-1:0];
                    oi_n  = oi + (MAX_LOG+1)'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                conj_n  = 1'b0;
                stage_n = '0;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_log    <= '0;
            brev       <= 1'b0;
            tw_conj    <= 1'b0;
            stage      <= '0;
            b          <= '0;
            leg        <= 1'b0;
            dcnt       <= '0;
            oi         <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            rd_ptr     <= '0;
            rd_angle   <= '0;
            finish_fft <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            for (int unsigned k = 0; k < WB_LAT; k++) begin
                en_sr[k]  <= 1'b0;
                ptr_sr[k] <= '0;
            end
        end else begin
            state      <= state_n;
            len_log    <= len_log_n;
            brev       <= brev_n;
            tw_conj    <= conj_n;
            stage      <= stage_n;
            b          <= b_n;
            leg        <= leg_n;
            dcnt       <= dcnt_n;
            oi         <= oi_n;
            busy       <= busy_n;
            rd_en      <= rd_en_n;
            rd_ptr     <= ptr_n;
            rd_angle   <= ang_n;
            finish_fft <= fin_n;
            out_valid  <= ov_n;
            done       <= done_n;
            en_sr[0]   <= rd_en;
            ptr_sr[0]  <= rd_en ? rd_ptr : '0;
            for (int unsigned k = 1; k < WB_LAT; k++) begin
                en_sr[k]  <= en_sr[k-1];
                ptr_sr[k] <= ptr_sr[k-1];
            end
        end
    end

    assign wr_en  = en_sr[WB_LAT-1];
    assign wr_ptr = ptr_sr[WB_LAT-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: cycle-by-cycle comparison against
// a schedule computed arithmetically from the stage/read-out rules.
module tb_fft_stage_sequencer;
    localparam int MAX_LOG = 10;
    localparam int WB_LAT  = 3;
    localparam int TW_W    = MAX_LOG - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [3:0]         log2n = '0;
    logic               inverse = 1'b0;
    logic               bitrev_out = 1'b0;
    logic               en_out = 1'b0;
    logic               busy, rd_en, tw_conj, wr_en, finish_fft, out_valid, done;
    logic [MAX_LOG-1:0] rd_ptr, wr_ptr;
    logic [TW_W-1:0]    rd_angle;
    logic [3:0]         stage;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int obs_q[$];

    fft_stage_sequencer #(.MAX_LOG(MAX_LOG), .WB_LAT(WB_LAT), .TW_W(TW_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n), .inverse(inverse),
        .bitrev_out(bitrev_out), .en_out(en_out), .busy(busy), .rd_en(rd_en),
        .rd_ptr(rd_ptr), .rd_angle(rd_angle), .tw_conj(tw_conj), .stage(stage),
        .wr_en(wr_en), .wr_ptr(wr_ptr), .finish_fft(finish_fft), .out_valid(out_valid),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int v);
        if (v < 1) return 1;
        if (v > MAX_LOG) return MAX_LOG;
        return v;
    endfunction

    function automatic int ref_addr(input int s, input int b, input int leg);
        int h;
        h = 1 << s;
        return (b >> s) * 2 * h + (b & (h - 1)) + leg * h;
    endfunction

    function automatic int ref_angle(input int s, input int b);
        return (b & ((1 << s) - 1)) << (MAX_LOG - 1 - s);
    endfunction

    function automatic int ref_rev(input int v, input int l);
        int r;
        r = 0;
        for (int k = 0; k < l; k++) r = (r << 1) | ((v >> k) & 1);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_rd_en"},  32'(rd_en), 0);
        check({tag, "_rd_ptr"}, 32'(rd_ptr), 0);
        check({tag, "_angle"},  32'(rd_angle), 0);
        check({tag, "_conj"},   32'(tw_conj), 0);
        check({tag, "_stage"},  32'(stage), 0);
        check({tag, "_wr_en"},  32'(wr_en), 0);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), 0);
        check({tag, "_finish"}, 32'(finish_fft), 0);
        check({tag, "_valid"},  32'(out_valid), 0);
        check({tag, "_done"},   32'(done), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 0);
            check("idle_wr_en", 32'(wr_en), 0);
            check("idle_rd_en", 32'(rd_en), 0);
        end
    endtask

    // en_mode: 0 = en_out held high, 1 = random, 2 = 1,0,0,1,1 then 0 x5 then high
    task automatic run_fft(input int lin, input bit inv, input bit brev, input int en_mode,
                           input bit poke, input int abort_at, output int ov_window);
        int L, N, P, F, last, t, issued, q, limit, k;
        bit prev_en, e_rd, e_wr, e_ov, stop;
        int e_ptr, e_ang, e_st, e_wptr;
        L = clamp_len(lin);
        N = 1 << L;
        P = N + WB_LAT;
        F = L * P + 1;
        limit = F + 8 * N + 200;
        obs_q.delete();
        log2n = 4'(lin);
        inverse = inv;
        bitrev_out = brev;
        start = 1'b1;
        en_out = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        t = 1; issued = 0; last = -1; ov_window = 0; prev_en = 1'b0; stop = 1'b0;
        while (!stop) begin
            e_rd = 0; e_wr = 0; e_ov = 0; e_ptr = 0; e_ang = 0; e_st = 0; e_wptr = 0;
            if (t < F) begin
                k = (t - 1) % P;
                e_st = (t - 1) / P;
                if (k < N) begin
                    e_rd = 1; e_ptr = ref_addr(e_st, k / 2, k % 2); e_ang = ref_angle(e_st, k / 2);
                end
            end
            if (t - WB_LAT >= 1 && t - WB_LAT < F) begin
                k = (t - WB_LAT - 1) % P;
                if (k < N) begin
                    e_wr = 1; e_wptr = ref_addr((t - WB_LAT - 1) / P, k / 2, k % 2);
                end
            end
            if (t - 1 >= F && prev_en && issued < N) begin
                e_ov = 1;
                e_ptr = brev ? ref_rev(issued, L) : issued;
                issued++;
                if (issued == N) last = t;
            end
            check("busy", 32'(busy), 32'((last < 0) || (t <= last + 1)));
            check("rd_en", 32'(rd_en), 32'(e_rd));
            check("rd_ptr", 32'(rd_ptr), 32'(e_ptr));
            check("rd_angle", 32'(rd_angle), 32'(e_ang));
            check("wr_en", 32'(wr_en), 32'(e_wr));
            check("wr_ptr", 32'(wr_ptr), 32'(e_wptr));
            check("finish_fft", 32'(finish_fft), 32'(t == F));
            check("out_valid", 32'(out_valid), 32'(e_ov));
            check("done", 32'(done), 32'(last >= 0 && t == last + 1));
            if (t < F) check("stage", 32'(stage), 32'(e_st));
            if (last < 0 || t <= last + 1) check("tw_conj", 32'(tw_conj), 32'(inv));
            if (out_valid === 1'b1) obs_q.push_back(int'(rd_ptr));
            if (out_valid === 1'b1 && t >= F + 1 && t <= F + 10) ov_window++;
            if (t == abort_at || (last >= 0 && t == last + 2)) begin
                stop = 1'b1;
            end else if (t > limit) begin
                check("timeout_issued", 32'(issued), 32'(N));
                stop = 1'b1;
            end else begin
                q = t - F;
                case (en_mode)
                    0: en_out = 1'b1;
                    1: en_out = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (q < 0) en_out = 1'($urandom_range(0, 1));
                        else if (q < 5) en_out = (q == 0 || q == 3 || q == 4);
                        else if (q < 10) en_out = 1'b0;
                        else en_out = 1'b1;
                    end
                endcase
                prev_en = en_out;
                if (poke) begin
                    start = ($urandom_range(0, 7) == 0);
                    log2n = 4'($urandom);
                    inverse = 1'($urandom);
                    bitrev_out = 1'($urandom);
                end
                @(posedge clk); #1;
                t++;
            end
        end
        start = 1'b0;
        en_out = 1'b0;
    endtask

    initial begin
        int ovw;
        int exp_rev[8];
        exp_rev = '{0, 4, 2, 6, 1, 5, 3, 7};

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        run_fft(4, 1'b0, 1'b0, 0, 1'b0, -1, ovw);

        run_fft(3, 1'b0, 1'b1, 0, 1'b0, -1, ovw);
        check("rev_count", 32'(obs_q.size()), 8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++) check("rev_order", 32'(obs_q[i]), 32'(exp_rev[i]));

        run_fft(0, 1'b0, 1'b0, 1, 1'b0, -1, ovw);
        run_fft(12, 1'b0, 1'($urandom), 0, 1'b0, -1, ovw);
        run_fft(5, 1'b1, 1'($urandom), 1, 1'b1, -1, ovw);

        run_fft(2, 1'b0, 1'b0, 2, 1'b0, -1, ovw);
        check("en_pattern_valid_count", 32'(ovw), 3);

        // abort in stage 2 of an N=16 run while write-backs are still in flight
        run_fft(4, 1'b1, 1'b0, 0, 1'b0, 45, ovw);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_hold_wr_en", 32'(wr_en), 0);
        end
        rst_n = 1'b1;
        idle_cycles(WB_LAT + 2);
        run_fft(4, 1'b1, 1'b1, 1, 1'b0, -1, ovw);

        for (int r = 0; r < 4; r++) begin
            run_fft($urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom_range(0, 1),
                    1'($urandom), -1, ovw);
            idle_cycles(1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
